// File: rtl/conv_pkg.sv
// Shared definitions for the strided-convolution window scheduler.
//   - default geometry (image side, kernel side, stride, data width)
//   - output-side derivation and index-width helpers
//   - scheduler FSM state encoding and index typedefs at default geometry
package conv_pkg;

  localparam int DEF_M      = 7;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 2;
  localparam int DEF_DW     = 8;

  // Output side length for a valid (no padding) strided convolution.
  function automatic int out_side(input int m, input int k, input int s);
    return (m - k) / s + 1;
  endfunction

  // Index width that never collapses to zero bits for a side of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_OUT = out_side(DEF_M, DEF_K, DEF_STRIDE);

  typedef logic [idx_w(DEF_M)-1:0]   img_idx_t;
  typedef logic [idx_w(DEF_K)-1:0]   ker_idx_t;
  typedef logic [idx_w(DEF_OUT)-1:0] out_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate register for one convolution window.
//   clock, reset : clock and asynchronous active-low reset
//   clear        : zero the accumulator (wins over en)
//   en           : add a*b into the accumulator
//   a, b         : unsigned DW-bit operands
//   acc          : running sum, wraps modulo 2^DW
module conv_mac #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  // The sum is kept mod 2^DW, so only the low DW bits of the product matter.
  logic [DW-1:0] prod_lo;
  assign prod_lo = DW'(a * b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + prod_lo;
  end

endmodule

// File: rtl/conv_window_sched.sv
// Sequencer for a 2-D strided convolution over an MxM image in external
// synchronous (1-cycle latency) memories. Output windows are walked in
// row-major order; each window issues KxK image/coefficient reads with the
// coefficient index flipped (kernel applied rotated 180 degrees), then the
// window sum is offered on a valid/ready result port.
//   clock, reset            : clock, asynchronous active-low reset
//   start / busy / done     : pass control and status
//   img_rd_*                : image read port (en, row, col, data)
//   coef_rd_*               : kernel read port (en, row, col, data)
//   res_valid/ready/data    : result handshake and window sum
//   res_row / res_col       : output coordinate of res_data
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int M      = DEF_M,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE,
  parameter int DW     = DEF_DW,
  parameter int OUT    = out_side(M, K, STRIDE),
  parameter int AW     = idx_w(M),
  parameter int KW     = idx_w(K),
  parameter int OW     = idx_w(OUT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          img_rd_en,
  output logic [AW-1:0] img_rd_row,
  output logic [AW-1:0] img_rd_col,
  input  logic [DW-1:0] img_rd_data,
  output logic          coef_rd_en,
  output logic [KW-1:0] coef_rd_row,
  output logic [KW-1:0] coef_rd_col,
  input  logic [DW-1:0] coef_rd_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [OW-1:0] res_row,
  output logic [OW-1:0] res_col
);

  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT - 1);

  state_t        state, state_nxt;
  logic [OW-1:0] orow, ocol;     // window origin in output coordinates
  logic [KW-1:0] wr, wc;         // tap within the window
  logic          rd_en;
  logic          rd_vld;         // read data returning this cycle
  logic          mac_clear;
  logic [DW-1:0] acc;

  logic tap_last, win_last;
  assign tap_last = (wr == K_LAST) && (wc == K_LAST);
  assign win_last = (orow == O_LAST) && (ocol == O_LAST);

  // ---------------- next state / control ----------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    res_valid = 1'b0;
    mac_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          mac_clear = 1'b1;
        end
      end
      FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (tap_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        // last read's data is on the bus now and lands in acc at this edge
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          if (win_last) state_nxt = DONE;
          else begin
            state_nxt = FETCH;
            mac_clear = 1'b1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- state, counters, read-valid pipe ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      orow   <= '0;
      ocol   <= '0;
      wr     <= '0;
      wc     <= '0;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            orow <= '0;
            ocol <= '0;
            wr   <= '0;
            wc   <= '0;
          end
        end
        FETCH: begin
          // column first; (K-1,K-1) wraps back to (0,0) for the next window
          if (wc == K_LAST) begin
            wc <= '0;
            wr <= (wr == K_LAST) ? '0 : wr + 1'b1;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        WRITE: begin
          if (res_ready) begin
            wr <= '0;
            wc <= '0;
            if (ocol == O_LAST) begin
              ocol <= '0;
              orow <= orow + 1'b1;
            end else begin
              ocol <= ocol + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read addressing ----------------
  logic [AW-1:0] pix_row, pix_col;
  assign pix_row = AW'(int'(orow) * STRIDE + int'(wr));
  assign pix_col = AW'(int'(ocol) * STRIDE + int'(wc));

  assign img_rd_en   = rd_en;
  assign coef_rd_en  = rd_en;
  assign img_rd_row  = rd_en ? pix_row : '0;
  assign img_rd_col  = rd_en ? pix_col : '0;
  // flipped coefficient index gives the 180-degree kernel rotation
  assign coef_rd_row = rd_en ? (K_LAST - wr) : '0;
  assign coef_rd_col = rd_en ? (K_LAST - wc) : '0;

  // ---------------- accumulator ----------------
  conv_mac #(.DW(DW)) u_mac (
    .clock (clock),
    .reset (reset),
    .clear (mac_clear),
    .en    (rd_vld),
    .a     (img_rd_data),
    .b     (coef_rd_data),
    .acc   (acc)
  );

  // ---------------- result port ----------------
  assign res_data = res_valid ? acc  : '0;
  assign res_row  = res_valid ? orow : '0;
  assign res_col  = res_valid ? ocol : '0;

endmodule

// File: tb/tb_conv_window_sched.sv
module tb_conv_window_sched;

  localparam int M = 7, K = 3, DW = 8, AW = 3, KW = 2, OW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          res_ready = 1'b1;
  logic          busy, done;
  logic          img_rd_en, coef_rd_en;
  logic [AW-1:0] img_rd_row, img_rd_col;
  logic [KW-1:0] coef_rd_row, coef_rd_col;
  logic [DW-1:0] img_rd_data = '0, coef_rd_data = '0;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [OW-1:0] res_row, res_col;

  conv_window_sched dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_rd_row(img_rd_row), .img_rd_col(img_rd_col),
    .img_rd_data(img_rd_data),
    .coef_rd_en(coef_rd_en), .coef_rd_row(coef_rd_row), .coef_rd_col(coef_rd_col),
    .coef_rd_data(coef_rd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col)
  );

  always #5 clock = ~clock;

  // ---------------- memories (1-cycle read latency) ----------------
  logic [7:0] img_mem  [64];
  logic [7:0] kern_mem [16];

  always @(posedge clock) begin
    if (img_rd_en) begin
      img_rd_data  <= img_mem[int'(img_rd_row) * 7 + int'(img_rd_col)];
      coef_rd_data <= kern_mem[int'(coef_rd_row) * 4 + int'(coef_rd_col)];
    end
  end

  task automatic load_img(input int mode);
    for (int i = 0; i < 64; i++) img_mem[i] = 8'h0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        img_mem[r * 7 + c] = (mode == 0) ? 8'(7 * r + c) : (mode == 1) ? 8'd255 : 8'd1;
  endtask

  // mode 0: single 1 at [1][1]; 1: single 1 at [0][0]; 2: all ones
  task automatic load_kern(input int mode);
    for (int i = 0; i < 16; i++) kern_mem[i] = 8'h0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (mode == 2 || (mode == 0 && r == 1 && c == 1) || (mode == 1 && r == 0 && c == 0))
          kern_mem[r * 4 + c] = 8'd1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
  } res_t;

  res_t sb[$];
  res_t mon_e;
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0, t0 = 0;
  int   first_rel = -1, done_rel = -1, done_cnt = 0, pop_cnt = 0, stall_n = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle interface checks and result pops, sampled on negedge.
  always @(negedge clock) begin
    if (reset) begin
      check("rd_lockstep", int'(coef_rd_en), int'(img_rd_en));
      if (img_rd_en)
        check("rd_bounds", int'(img_rd_row < 3'(M) && img_rd_col < 3'(M) &&
                                coef_rd_row < 2'(K) && coef_rd_col < 2'(K)), 1);
      else
        check("rd_idle_addr", int'({img_rd_row, img_rd_col, coef_rd_row, coef_rd_col}), 0);
      if (res_valid) begin
        if (first_rel < 0) first_rel = cyc - t0;
        check("no_rd_in_write", int'(img_rd_en), 0);
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else if (res_ready) begin
          mon_e = sb.pop_front();
          check("res_data", int'(res_data), int'(mon_e.data));
          check("res_row",  int'(res_row),  int'(mon_e.row));
          check("res_col",  int'(res_col),  int'(mon_e.col));
          pop_cnt++;
        end else begin
          stall_n++;
          check("stall_hold", int'({res_data, res_row, res_col}), int'(sb[0]));
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] e_ctr  [9];
  logic [7:0] e_flip [9];
  logic [7:0] e_sat  [9];
  logic [7:0] e_one  [9];

  task automatic push_exp(input logic [7:0] e [9]);
    for (int i = 0; i < 9; i++) sb.push_back(res_t'{e[i], 2'(i / 3), 2'(i % 3)});
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    t0 = cyc;                 // the following edge accepts start (edge 0)
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_pass(input string nm, input logic [7:0] e [9], input bit chk_time);
    int d0, n;
    d0 = done_cnt;
    pop_cnt = 0; first_rel = -1; done_rel = -1;
    push_exp(e);
    pulse_start();
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    check({nm, "_done_pulses"}, done_cnt - d0, 1);
    check({nm, "_handshakes"}, pop_cnt, 9);
    check({nm, "_sb_left"}, sb.size(), 0);
    check({nm, "_idle_busy"}, int'(busy), 0);
    if (chk_time) begin
      check({nm, "_first_valid_cyc"}, first_rel, 11);
      check({nm, "_done_cyc"}, done_rel, 100);
    end
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pop_cnt < target && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    if (pop_cnt < target) check("wait_pops_timeout", pop_cnt, target);
  endtask

  function automatic int outs_vec();
    return int'({busy, done, img_rd_en, img_rd_row, img_rd_col, coef_rd_en,
                 coef_rd_row, coef_rd_col, res_valid, res_data, res_row, res_col});
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    e_ctr  = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
    e_flip = '{16, 18, 20, 30, 32, 34, 44, 46, 48};
    e_sat  = '{247, 247, 247, 247, 247, 247, 247, 247, 247};
    e_one  = '{9, 9, 9, 9, 9, 9, 9, 9, 9};

    // reset state
    #12;
    check("reset_outputs", outs_vec(), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_outputs", outs_vec(), 0);

    // centre tap, timing
    load_img(0); load_kern(0);
    run_pass("centre", e_ctr, 1'b1);

    // corner tap exercises the coefficient flip
    load_kern(1);
    run_pass("flip", e_flip, 1'b1);

    // 9*255 wraps to 247
    load_img(1); load_kern(2);
    run_pass("wrap", e_sat, 1'b1);

    // back-pressure on the 2nd result for 5 cycles
    load_img(2); load_kern(2);
    stall_n = 0;
    fork
      run_pass("stall", e_one, 1'b0);
      begin
        int n;
        wait_pops(1);
        res_ready = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
          @(posedge clock); #1;
          n++;
        end
        repeat (5) @(posedge clock);
        #1;
        res_ready = 1'b1;
      end
    join
    check("stall_cycles", stall_n, 5);

    // start pulse while busy is ignored
    load_img(0); load_kern(0);
    fork
      run_pass("busy_start", e_ctr, 1'b1);
      begin
        wait_pops(2);
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
      end
    join

    // reset during the 4th window's fetch abandons the pass
    d0 = done_cnt;
    pop_cnt = 0;
    push_exp(e_ctr);
    pulse_start();
    wait_pops(3);
    repeat (2) @(posedge clock);
    #1;
    check("fetch_before_reset", int'(img_rd_en), 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", outs_vec(), 0);
    sb.delete();
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs_held", outs_vec(), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("no_done_after_abort", done_cnt - d0, 0);

    // full pass after recovery
    run_pass("recover", e_ctr, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
